// File: rtl/life_meter_display_pkg.sv
// Shared types and sprite geometry for the life meter overlay.
package life_meter_display_pkg;
    typedef enum logic {IDLE, BLINK} state_e;

    localparam int          SPRITE_W      = 16;
    localparam int          SPRITE_H      = 16;
    localparam int          EMPTY_ROW_OFS = 16;
    localparam logic [11:0] DEF_BG_COLOR  = 12'h6DE;
endpackage

// File: rtl/hearts_rom.sv
// Heart sprite ROM: rows 0-15 full heart, rows 16-31 empty heart; one-cycle registered read.
module hearts_rom (
    input  logic        clk,
    input  logic [4:0]  row,
    input  logic [3:0]  col,
    output logic [11:0] color_data
);
    logic [15:0] w_mask;
    logic [11:0] w_pix;

    // Bit 15 is the leftmost pixel; both halves share the same silhouette.
    always_comb begin
        case (row[3:0])
            4'd2:    w_mask = 16'h3838;
            4'd3:    w_mask = 16'h7C7C;
            4'd4:    w_mask = 16'hFEFE;
            4'd5:    w_mask = 16'hFFFE;
            4'd6:    w_mask = 16'hFFFE;
            4'd7:    w_mask = 16'hFFFE;
            4'd8:    w_mask = 16'h7FFC;
            4'd9:    w_mask = 16'h3FF8;
            4'd10:   w_mask = 16'h1FF0;
            4'd11:   w_mask = 16'h0FE0;
            4'd12:   w_mask = 16'h07C0;
            4'd13:   w_mask = 16'h0380;
            4'd14:   w_mask = 16'h0100;
            default: w_mask = 16'h0000;
        endcase
        if (w_mask[4'd15 - col])
            w_pix = row[4] ? 12'h888 : 12'hF00;
        else
            w_pix = 12'h6DE;
    end

    always_ff @(posedge clk)
        color_data <= w_pix;
endmodule

// File: rtl/life_meter_display.sv
// Row of heart sprites with frame-synchronous count updates and blinking of lost hearts.
module life_meter_display
    import life_meter_display_pkg::*;
#(
    parameter int          MAX_HEARTS   = 3,
    parameter int          X0           = 240,
    parameter int          Y0           = 16,
    parameter int          SPACING      = 16,
    parameter int          BLINK_FRAMES = 60,
    parameter int          BLINK_PERIOD = 8,
    parameter logic [11:0] BG_COLOR     = DEF_BG_COLOR
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        frame_tick,
    input  logic [3:0]  num_hearts,
    output logic [11:0] color_data,
    output logic        hearts_on,
    output logic        blinking
);
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    state_e             r_state, w_state_nxt;
    logic [3:0]         r_shown, r_lo, r_hi, w_shown_nxt, w_lo_nxt, w_hi_nxt, w_req;
    logic [CNT_W-1:0]   r_frame_cnt, w_frame_cnt_nxt;
    logic               r_vis, r_primed, w_vis_nxt, w_primed_nxt;
    logic               r_in_slot, r_blinking, w_in_slot;
    logic [4:0]         w_row;
    logic [3:0]         w_col;

    assign w_req = (num_hearts > 4'(MAX_HEARTS)) ? 4'(MAX_HEARTS) : num_hearts;

    always_comb begin
        w_state_nxt     = r_state;
        w_shown_nxt     = r_shown;
        w_lo_nxt        = r_lo;
        w_hi_nxt        = r_hi;
        w_frame_cnt_nxt = r_frame_cnt;
        w_vis_nxt       = r_vis;
        w_primed_nxt    = r_primed;
        if (frame_tick) begin
            if (!r_primed) begin
                // First frame after reset just adopts the requested count.
                w_shown_nxt  = w_req;
                w_primed_nxt = 1'b1;
            end else if (w_req < r_shown) begin
                w_lo_nxt        = w_req;
                w_hi_nxt        = (r_state == IDLE) ? r_shown : r_hi;
                w_shown_nxt     = w_req;
                w_frame_cnt_nxt = '0;
                w_vis_nxt       = 1'b0;
                w_state_nxt     = BLINK;
            end else if (w_req > r_shown) begin
                w_shown_nxt = w_req;
                w_state_nxt = IDLE;
            end else if (r_state == BLINK) begin
                if (r_frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_frame_cnt_nxt = r_frame_cnt + 1'b1;
                    if (((int'(r_frame_cnt) + 1) % BLINK_PERIOD) == 0)
                        w_vis_nxt = ~r_vis;
                end
            end
        end
    end

    always_comb begin
        w_in_slot = 1'b0;
        w_row     = '0;
        w_col     = '0;
        for (int i = 0; i < MAX_HEARTS; i++) begin
            if (x >= 10'(X0 + i*SPACING) && x < 10'(X0 + i*SPACING + SPRITE_W) &&
                y >= 10'(Y0) && y < 10'(Y0 + SPRITE_H)) begin
                w_in_slot = 1'b1;
                w_col     = 4'(x - 10'(X0 + i*SPACING));
                if (i < int'(r_shown) ||
                    (r_state == BLINK && r_vis && i >= int'(r_lo) && i < int'(r_hi)))
                    w_row = 5'(y - 10'(Y0));
                else
                    w_row = 5'(y - 10'(Y0) + 10'(EMPTY_ROW_OFS));
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_shown     <= '0;
            r_lo        <= '0;
            r_hi        <= '0;
            r_frame_cnt <= '0;
            r_vis       <= 1'b1;
            r_primed    <= 1'b0;
            r_in_slot   <= 1'b0;
            r_blinking  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shown     <= w_shown_nxt;
            r_lo        <= w_lo_nxt;
            r_hi        <= w_hi_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_vis       <= w_vis_nxt;
            r_primed    <= w_primed_nxt;
            r_in_slot   <= w_in_slot;
            r_blinking  <= (w_state_nxt == BLINK);
        end
    end

    hearts_rom u_rom (
        .clk        (clk),
        .row        (w_row),
        .col        (w_col),
        .color_data (color_data)
    );

    // Slot flag is aligned with the ROM's registered colour.
    assign hearts_on = r_in_slot && (color_data != BG_COLOR);
    assign blinking  = r_blinking;
endmodule

// File: tb/tb_life_meter_display.sv
// Directed bench for life_meter_display with immediate-assertion checks.
module tb_life_meter_display;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic        frame_tick = 1'b0;
    logic [3:0]  num_hearts = '0;
    logic [11:0] color_data;
    logic        hearts_on;
    logic        blinking;

    int n_cmp = 0;
    int n_fail = 0;

    localparam logic [11:0] FULL  = 12'hF00;
    localparam logic [11:0] EMPTY = 12'h888;
    localparam logic [11:0] BG    = 12'h6DE;

    life_meter_display dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .x          (x),
        .y          (y),
        .frame_tick (frame_tick),
        .num_hearts (num_hearts),
        .color_data (color_data),
        .hearts_on  (hearts_on),
        .blinking   (blinking)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick(input logic [3:0] n, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            @(negedge clk);
            num_hearts = n;
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    endtask

    task automatic pix(input string tag, input int px, input int py,
                       input logic [11:0] ec, input logic eo);
        @(negedge clk);
        x = 10'(px);
        y = 10'(py);
        @(negedge clk);
        check({tag, "_color"}, color_data, ec);
        check({tag, "_on"}, {11'b0, hearts_on}, {11'b0, eo});
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #2;
        check("rst_on", {11'b0, hearts_on}, 12'h0);
        check("rst_blink", {11'b0, blinking}, 12'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Unprimed: nothing shown, slot 0 draws the empty heart.
        pix("unprimed_s0", 244, 20, EMPTY, 1'b1);

        tick(4'd3, 1);
        check("prime_blink", {11'b0, blinking}, 12'h0);
        pix("prime_s0", 244, 20, FULL, 1'b1);
        pix("prime_s2", 276, 20, FULL, 1'b1);

        // 3 -> 1: slots 1-2 blink, empty first 8 frames.
        tick(4'd1, 1);
        check("drop_blink", {11'b0, blinking}, 12'h1);
        pix("drop_s0", 244, 20, FULL, 1'b1);
        pix("drop_s1_f0", 260, 20, EMPTY, 1'b1);
        tick(4'd1, 7);
        pix("drop_s1_f7", 260, 20, EMPTY, 1'b1);
        tick(4'd1, 1);
        pix("drop_s1_f8", 260, 20, FULL, 1'b1);
        pix("drop_s2_f8", 276, 20, FULL, 1'b1);
        tick(4'd1, 8);
        pix("drop_s1_f16", 260, 20, EMPTY, 1'b1);
        tick(4'd1, 43);
        check("blink_f59", {11'b0, blinking}, 12'h1);
        tick(4'd1, 1);
        check("blink_end", {11'b0, blinking}, 12'h0);
        pix("end_s1", 260, 20, EMPTY, 1'b1);
        pix("end_s2", 276, 20, EMPTY, 1'b1);

        // 3 -> 2, then to 0 mid-blink: widened range, counter restarts.
        tick(4'd3, 1);
        check("grow_blink", {11'b0, blinking}, 12'h0);
        tick(4'd2, 1);
        check("d2_blink", {11'b0, blinking}, 12'h1);
        pix("d2_s1", 260, 20, FULL, 1'b1);
        pix("d2_s2", 276, 20, EMPTY, 1'b1);
        tick(4'd2, 2);
        tick(4'd0, 1);
        pix("d0_s0_f0", 244, 20, EMPTY, 1'b1);
        tick(4'd0, 7);
        pix("d0_s0_f7", 244, 20, EMPTY, 1'b1);
        tick(4'd0, 1);
        pix("d0_s0_f8", 244, 20, FULL, 1'b1);
        pix("d0_s1_f8", 260, 20, FULL, 1'b1);
        pix("d0_s2_f8", 276, 20, FULL, 1'b1);

        // Increase during blink ends it at once.
        tick(4'd3, 1);
        check("inc_blink", {11'b0, blinking}, 12'h0);
        pix("inc_s0", 244, 20, FULL, 1'b1);
        pix("inc_s2", 276, 20, FULL, 1'b1);

        // Clamp: 9 behaves as 3, so a later request of 3 is not a loss.
        tick(4'd1, 1);
        check("c1_blink", {11'b0, blinking}, 12'h1);
        tick(4'd9, 1);
        check("c9_blink", {11'b0, blinking}, 12'h0);
        pix("c9_s2", 276, 20, FULL, 1'b1);
        tick(4'd3, 1);
        check("c3_blink", {11'b0, blinking}, 12'h0);

        pix("outside", 288, 20, BG, 1'b0);
        pix("bg_in_slot", 240, 16, BG, 1'b0);
        pix("below_slot", 244, 36, BG, 1'b0);

        // Reset mid-blink clears outputs asynchronously.
        tick(4'd0, 1);
        check("pre_rst_blink", {11'b0, blinking}, 12'h1);
        pix("pre_rst_s0", 244, 20, EMPTY, 1'b1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_blink", {11'b0, blinking}, 12'h0);
        check("async_on", {11'b0, hearts_on}, 12'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tick(4'd1, 1);
        check("reprime_blink", {11'b0, blinking}, 12'h0);
        pix("reprime_s0", 244, 20, FULL, 1'b1);
        pix("reprime_s1", 260, 20, EMPTY, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
